axis_mt_prng: RTL and testbench
===============================

Name: axis_mt_prng

Overview:
- Parametrised AXI4-Stream Mersenne Twister generator.
- WIDTH selects the algorithm: MT19937 (32-bit) or MT19937-64 (64-bit).
- Sits as a free-running random source in the stream fabric.
- Supports runtime re-seeding, seed abort/restart, and standard AXIS backpressure: the output register holds while tvalid is high and tready is low.

Parameters:
- WIDTH, 64, word width; legal values are 32 (MT19937) or 64 (MT19937-64); any other value is a compile-time error.
- DEFAULT_SEED, 5489, seed used when output is requested before any seed_start.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- output_axis_tdata  output  WIDTH  tempered random word
- output_axis_tvalid  output  1  tdata valid
- output_axis_tready  input  1  sink ready
- busy  output  1  state-table initialisation in progress
- seed_val  input  WIDTH  seed value
- seed_start  input  1  single-cycle pulse; load seed_val and re-initialise

Behaviour:
- Clocking and reset: one clock (clk). rst is synchronous and active-high; all state changes on the rising edge of clk.
- Reset state: tvalid=0, tdata=0, busy=0, FSM=IDLE, table marked unseeded. State RAM contents are not reset.
- Constants for WIDTH=32:
  - N=624, M=397, A=0x9908B0DF, F=1812433253, init shift 30
  - upper mask = bit 31, lower = bits 30:0
  - tempering: u=11/d=0xFFFFFFFF, s=7/b=0x9D2C5680, t=15/c=0xEFC60000, l=18
- Constants for WIDTH=64:
  - N=312, M=156, A=0xB5026F5AA96619E9, F=6364136223846793005, init shift 62
  - upper = bits 63:31, lower = bits 30:0
  - tempering: u=29/d=0x5555555555555555, s=17/b=0x71D67FFFEDA60000, t=37/c=0xFFF7EEE000000000, l=43
- State table: N x WIDTH RAM, one write port and two synchronous read ports (index i+1 and i+M, both mod N). All arithmetic is modulo 2^WIDTH.
- FSM states:
  - IDLE: serves output requests.
  - SEED_MUL: computes F*(x ^ (x>>shift)), serial shift-add, one bit per cycle, WIDTH cycles.
  - SEED_WR: writes mt[i] = product + i, advances i; returns to SEED_MUL if i<N, else SEED_FIN.
  - SEED_FIN: primes both read pointers; sets i=0; goes to IDLE.
- Seeding:
  - seed_start in any state (including SEED_*) writes mt[0]=seed_val, sets i=1, enters SEED_MUL and clears tvalid. Stale words are discarded; seed restart is permitted mid-seed.
  - If the table is unseeded and the generator advances, DEFAULT_SEED is seeded as if by seed_start.
- busy: registered; high from the cycle after a seed trigger until the cycle after SEED_FIN. Total seed time ≤ N*(WIDTH+1)+4 cycles.
- Generation (IDLE only):
  - Advance condition: table seeded, and (!tvalid || tready).
  - On advance: y = upper(mt[i]) | lower(mt[i+1]); mt[i] = mt[i+M] ^ (y>>1) ^ (y[0] ? A : 0); tdata = temper(new mt[i]); tvalid=1; i wraps at N-1 -> 0.
  - Latency: one word per cycle under continuous tready. tdata is registered one cycle after the advance.
- Simultaneous events:
  - rst beats seed_start; seed_start beats advance.
  - tready with tvalid=1 during SEED_*: the word is consumed and tvalid drops. No new word appears until seeding completes.
- Read-during-write: the write to mt[i] and the read of mt[i+M] never alias, since M≠0. The read pointer for the next cycle is computed from next-state i.

Optional Feature:
- MT_PRNG_FAST_SEED_EN
- Defined: SEED_MUL is a single-cycle full WIDTH x WIDTH multiply (low WIDTH bits). Seed time ≤ 2N+4 cycles.
- Undefined: serial shift-add as above. No multiplier inferred.
- Output sequences are bit-identical in both builds.

Test Plan:
- WIDTH=32, reset, tready held high, no seed_start -> auto-seeds 5489; first tdata=3499211612; 10000th tdata=4123659995.
- WIDTH=64, same stimulus -> first tdata=14514284786278117030; 10000th tdata=9981545732273789042.
- WIDTH=64, seed_start with seed_val=5489 followed by tready=1 -> busy asserts; output matches the previous case word-for-word.
- Random tready toggling (50%) -> no word lost or duplicated; tdata stable while tvalid && !tready; 10000th accepted word still 9981545732273789042.
- seed_start pulse at the midpoint of an ongoing seed, seed_val=5489 -> restart; busy stays high; final sequence equals clean seed 5489.
- rst asserted mid-generation for one cycle -> next cycle tvalid=0, busy=0; subsequent output restarts from the DEFAULT_SEED sequence (first word per WIDTH as above).
- Repeat the first and second scenarios with MT_PRNG_FAST_SEED_EN defined -> identical words; seed time ≤ 2N+4 cycles.

Source files
------------

// File: rtl/axis_mt_prng.sv
// AXI4-Stream Mersenne Twister source: MT19937 (WIDTH=32) or MT19937-64 (WIDTH=64).
// Optional macro MT_PRNG_FAST_SEED_EN: single-cycle seeding multiply instead of serial shift-add.
module axis_mt_prng #(
    parameter int               WIDTH        = 64,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(5489)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] output_axis_tdata,
    output logic             output_axis_tvalid,
    input  logic             output_axis_tready,
    output logic             busy,
    input  logic [WIDTH-1:0] seed_val,
    input  logic             seed_start
);

    if (WIDTH != 32 && WIDTH != 64) begin : g_bad_width
        $error("axis_mt_prng: WIDTH must be 32 or 64");
    end

    localparam bit W64 = (WIDTH == 64);
    localparam int N   = W64 ? 312 : 624;
    localparam int M   = W64 ? 156 : 397;
    localparam int SH  = W64 ? 62 : 30;
    localparam int U   = W64 ? 29 : 11;
    localparam int S   = W64 ? 17 : 7;
    localparam int T   = W64 ? 37 : 15;
    localparam int L   = W64 ? 43 : 18;
    localparam int IW  = 10;

    localparam logic [63:0] A64 = W64 ? 64'hB502_6F5A_A966_19E9 : 64'h0000_0000_9908_B0DF;
    localparam logic [63:0] F64 = W64 ? 64'd6364136223846793005 : 64'd1812433253;
    localparam logic [63:0] D64 = W64 ? 64'h5555_5555_5555_5555 : 64'h0000_0000_FFFF_FFFF;
    localparam logic [63:0] B64 = W64 ? 64'h71D6_7FFF_EDA6_0000 : 64'h0000_0000_9D2C_5680;
    localparam logic [63:0] C64 = W64 ? 64'hFFF7_EEE0_0000_0000 : 64'h0000_0000_EFC6_0000;

    localparam logic [WIDTH-1:0] A     = A64[WIDTH-1:0];
    localparam logic [WIDTH-1:0] F     = F64[WIDTH-1:0];
    localparam logic [WIDTH-1:0] D     = D64[WIDTH-1:0];
    localparam logic [WIDTH-1:0] B     = B64[WIDTH-1:0];
    localparam logic [WIDTH-1:0] C     = C64[WIDTH-1:0];
    localparam logic [WIDTH-1:0] LOWER = WIDTH'(32'h7FFF_FFFF);
    localparam logic [WIDTH-1:0] UPPER = ~LOWER;

    typedef enum logic [1:0] {IDLE, SEED_MUL, SEED_WR, SEED_FIN} state_t;

    function automatic logic [WIDTH-1:0] temper(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] y;
        y = x ^ ((x >> U) & D);
        y = y ^ ((y << S) & B);
        y = y ^ ((y << T) & C);
        return y ^ (y >> L);
    endfunction

    function automatic logic [WIDTH-1:0] seed_mix(input logic [WIDTH-1:0] x);
        return x ^ (x >> SH);
    endfunction

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int k);
        int s;
        s = int'(a) + k;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    state_t           state;
    logic             seeded;
    logic [IW-1:0]    i;
    logic [WIDTH-1:0] mem [N];
    logic [WIDTH-1:0] mt_cur;
    logic [WIDTH-1:0] mt_nxt_p1;
    logic [WIDTH-1:0] mt_far_p1;
    logic [WIDTH-1:0] prod;
    logic [WIDTH-1:0] mcand;
`ifndef MT_PRNG_FAST_SEED_EN
    logic [WIDTH-1:0] mbits;
    logic [6:0]       cnt;
`endif

    logic             trig, adv, we, load_mul;
    logic [WIDTH-1:0] trig_val, y, gen_word, seed_word, wd, mul_src;
    logic [IW-1:0]    nxt_i, wa;

    always_comb begin
        trig      = 1'b0;
        trig_val  = seed_val;
        adv       = 1'b0;
        y         = (mt_cur & UPPER) | (mt_nxt_p1 & LOWER);
        gen_word  = mt_far_p1 ^ (y >> 1) ^ (y[0] ? A : '0);
        seed_word = prod + {{(WIDTH-IW){1'b0}}, i};
        nxt_i     = i;
        we        = 1'b0;
        wa        = i;
        wd        = gen_word;
        if (!rst) begin
            if (seed_start) begin
                trig = 1'b1;
            end else if (state == IDLE && !seeded && (!output_axis_tvalid || output_axis_tready)) begin
                trig     = 1'b1;
                trig_val = DEFAULT_SEED;
            end
            adv = !trig && state == IDLE && seeded && (!output_axis_tvalid || output_axis_tready);
            if (trig) begin
                nxt_i = IW'(1);
                we    = 1'b1;
                wa    = '0;
                wd    = trig_val;
            end else if (adv) begin
                nxt_i = (i == IW'(N-1)) ? '0 : i + 1'b1;
                we    = 1'b1;
            end else if (state == SEED_WR) begin
                nxt_i = i + 1'b1;
                we    = 1'b1;
                wd    = seed_word;
            end else if (state == SEED_FIN) begin
                nxt_i = '0;
            end
        end
        load_mul = trig || (state == SEED_WR);
        mul_src  = trig ? trig_val : seed_word;
    end

    // State table: read addresses follow next-state i so data is ready when i arrives
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        mt_nxt_p1 <= mem[wrap_add(nxt_i, 1)];
        mt_far_p1 <= mem[wrap_add(nxt_i, M)];
    end

    always_ff @(posedge clk) begin
        if (trig) mt_cur <= trig_val;
        else if (adv) mt_cur <= mt_nxt_p1;
        if (load_mul) begin
            mcand <= seed_mix(mul_src);
`ifndef MT_PRNG_FAST_SEED_EN
            mbits <= F;
            prod  <= '0;
`endif
        end else if (state == SEED_MUL) begin
`ifdef MT_PRNG_FAST_SEED_EN
            prod <= mcand * F;
`else
            if (mbits[0]) prod <= prod + mcand;
            mcand <= mcand << 1;
            mbits <= mbits >> 1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            seeded             <= 1'b0;
            busy               <= 1'b0;
            output_axis_tvalid <= 1'b0;
            output_axis_tdata  <= '0;
            i                  <= '0;
`ifndef MT_PRNG_FAST_SEED_EN
            cnt                <= '0;
`endif
        end else begin
            i <= nxt_i;
            if (trig) begin
                state              <= SEED_MUL;
                seeded             <= 1'b0;
                busy               <= 1'b1;
                output_axis_tvalid <= 1'b0;
`ifndef MT_PRNG_FAST_SEED_EN
                cnt                <= '0;
`endif
            end else begin
                if (output_axis_tready) output_axis_tvalid <= 1'b0;
                case (state)
                    IDLE: begin
                        if (adv) begin
                            output_axis_tvalid <= 1'b1;
                            output_axis_tdata  <= temper(gen_word);
                        end
                    end
                    SEED_MUL: begin
`ifdef MT_PRNG_FAST_SEED_EN
                        state <= SEED_WR;
`else
                        cnt <= cnt + 1'b1;
                        if (cnt == 7'(WIDTH-1)) state <= SEED_WR;
`endif
                    end
                    SEED_WR: begin
`ifndef MT_PRNG_FAST_SEED_EN
                        cnt <= '0;
`endif
                        state <= (i == IW'(N-1)) ? SEED_FIN : SEED_MUL;
                    end
                    SEED_FIN: begin
                        state  <= IDLE;
                        seeded <= 1'b1;
                        busy   <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axis_mt_prng.sv
// Bench for axis_mt_prng: both widths side by side against a table-at-a-time MT reference.
module tb_axis_mt_prng;

`ifdef MT_PRNG_FAST_SEED_EN
    localparam int SEED32 = 2*624 + 4;
    localparam int SEED64 = 2*312 + 4;
`else
    localparam int SEED32 = 624*33 + 4;
    localparam int SEED64 = 312*65 + 4;
`endif

    logic        clk;
    logic        r32, rdy32, ss32, v32, b32;
    logic [31:0] sv32, d32;
    logic        r64, rdy64, ss64, v64, b64;
    logic [63:0] sv64, d64;

    int          checks = 0;
    int          passes = 0;
    int          acc [2];
    logic        hold [2];
    logic [63:0] held [2];
    logic [63:0] first_w [2];
    logic [63:0] w10k [2];
    logic [63:0] m_mt [2][624];
    int          m_idx [2];

    axis_mt_prng #(.WIDTH(32), .DEFAULT_SEED(32'd5489)) u_dut32 (
        .clk(clk), .rst(r32), .output_axis_tdata(d32), .output_axis_tvalid(v32),
        .output_axis_tready(rdy32), .busy(b32), .seed_val(sv32), .seed_start(ss32)
    );

    axis_mt_prng #(.WIDTH(64), .DEFAULT_SEED(64'd5489)) u_dut64 (
        .clk(clk), .rst(r64), .output_axis_tdata(d64), .output_axis_tvalid(v64),
        .output_axis_tready(rdy64), .busy(b64), .seed_val(sv64), .seed_start(ss64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference: classic init_genrand + full-table twist, d=0 for 32-bit, d=1 for 64-bit
    task automatic m_seed(input int d, input logic [63:0] s);
        logic [63:0] x, msk, f;
        int          n;
        n   = d ? 312 : 624;
        msk = d ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        f   = d ? 64'd6364136223846793005 : 64'd1812433253;
        m_mt[d][0] = s & msk;
        for (int k = 1; k < n; k++) begin
            x = m_mt[d][k-1];
            x = x ^ (x >> (d ? 62 : 30));
            m_mt[d][k] = (f * x + 64'(k)) & msk;
        end
        m_idx[d] = n;
        acc[d]   = 0;
    endtask

    task automatic m_next(input int d, output logic [63:0] w);
        logic [63:0] y, up, a;
        int          n, mm;
        n  = d ? 312 : 624;
        mm = d ? 156 : 397;
        up = d ? 64'hFFFF_FFFF_8000_0000 : 64'h0000_0000_8000_0000;
        a  = d ? 64'hB502_6F5A_A966_19E9 : 64'h0000_0000_9908_B0DF;
        if (m_idx[d] >= n) begin
            for (int k = 0; k < n; k++) begin
                y = (m_mt[d][k] & up) | (m_mt[d][(k+1) % n] & 64'h7FFF_FFFF);
                m_mt[d][k] = m_mt[d][(k+mm) % n] ^ (y >> 1) ^ (y[0] ? a : 64'd0);
            end
            m_idx[d] = 0;
        end
        y = m_mt[d][m_idx[d]];
        m_idx[d]++;
        if (d == 0) begin
            y = y ^ (y >> 11);
            y = y ^ ((y << 7) & 64'h9D2C_5680);
            y = y ^ ((y << 15) & 64'hEFC6_0000);
            y = y ^ (y >> 18);
        end else begin
            y = y ^ ((y >> 29) & 64'h5555_5555_5555_5555);
            y = y ^ ((y << 17) & 64'h71D6_7FFF_EDA6_0000);
            y = y ^ ((y << 37) & 64'hFFF7_EEE0_0000_0000);
            y = y ^ (y >> 43);
        end
        w = y;
    endtask

    task automatic observe(input int d, input logic v, input logic rdy, input logic [63:0] data,
                           input logic r, input logic ss);
        logic [63:0] e;
        if (hold[d]) begin
            chk($sformatf("hold%0d_tvalid", d ? 64 : 32), 64'(v), 64'd1);
            chk($sformatf("hold%0d_tdata", d ? 64 : 32), data, held[d]);
        end
        hold[d] = 1'b0;
        if (!r && !ss) begin
            if (v && rdy) begin
                m_next(d, e);
                acc[d]++;
                chk($sformatf("word%0d_%0d", d ? 64 : 32, acc[d]), data, e);
                if (acc[d] == 1) first_w[d] = data;
                if (acc[d] == 10000) w10k[d] = data;
            end else if (v) begin
                hold[d] = 1'b1;
                held[d] = data;
            end
        end
    endtask

    always @(negedge clk) begin
        observe(0, v32, rdy32, {32'd0, d32}, r32, ss32);
        observe(1, v64, rdy64, d64, r64, ss64);
    end

    task automatic run32();
        int          t;
        logic [63:0] w;
        r32 = 1'b1; rdy32 = 1'b1; ss32 = 1'b0; sv32 = '0;
        m_seed(0, 64'd5489);
        m_next(0, w);
        chk("model32_first", w, 64'd3499211612);
        m_seed(0, 64'd5489);
        repeat (2) @(posedge clk);
        #1;
        chk("rst32_tvalid", 64'(v32), 64'd0);
        chk("rst32_busy", 64'(b32), 64'd0);
        chk("rst32_tdata", {32'd0, d32}, 64'd0);
        r32 = 1'b0;
        @(posedge clk); #1;
        chk("auto32_busy", 64'(b32), 64'd1);
        t = 1;
        while (b32 && t < SEED32 + 10) begin @(posedge clk); #1; t++; end
        chk("seed32_time", 64'(t <= SEED32), 64'd1);
        t = 0;
        while (acc[0] < 10000 && t < 12000) begin @(posedge clk); #1; t++; end
        chk("cnt32_10000", 64'(acc[0] >= 10000), 64'd1);
        chk("first32", first_w[0], 64'd3499211612);
        chk("w10k32", w10k[0], 64'd4123659995);
        sv32 = $urandom;
        ss32 = 1'b1;
        m_seed(0, {32'd0, sv32});
        @(posedge clk); #1;
        ss32 = 1'b0;
        chk("ss32_tvalid", 64'(v32), 64'd0);
        chk("ss32_busy", 64'(b32), 64'd1);
        t = 0;
        while ((b32 || acc[0] < 300) && t < SEED32 + 2000) begin
            rdy32 = 1'($urandom_range(0, 1));
            @(posedge clk); #1; t++;
        end
        chk("rand32_words", 64'(acc[0] >= 300), 64'd1);
    endtask

    task automatic run64();
        int          t;
        logic [63:0] w;
        r64 = 1'b1; rdy64 = 1'b0; ss64 = 1'b0; sv64 = '0;
        m_seed(1, 64'd5489);
        m_next(1, w);
        chk("model64_first", w, 64'd14514284786278117030);
        m_seed(1, 64'd5489);
        repeat (2) @(posedge clk);
        #1;
        chk("rst64_tvalid", 64'(v64), 64'd0);
        chk("rst64_busy", 64'(b64), 64'd0);
        chk("rst64_tdata", d64, 64'd0);
        r64 = 1'b0;
        repeat (SEED64 / 2) @(posedge clk);
        #1;
        chk("mid64_busy_before", 64'(b64), 64'd1);
        sv64 = 64'd5489;
        ss64 = 1'b1;
        m_seed(1, 64'd5489);
        @(posedge clk); #1;
        ss64 = 1'b0;
        chk("mid64_busy_after", 64'(b64), 64'd1);
        t = 1;
        while (b64 && t < SEED64 + 10) begin
            rdy64 = 1'($urandom_range(0, 1));
            @(posedge clk); #1; t++;
        end
        chk("seed64_time", 64'(t <= SEED64), 64'd1);
        chk("seed64_restarted", 64'(t > SEED64 / 2 + 8), 64'd1);
        t = 0;
        while (acc[1] < 10000 && t < 40000) begin
            rdy64 = 1'($urandom_range(0, 1));
            @(posedge clk); #1; t++;
        end
        chk("cnt64_10000", 64'(acc[1] >= 10000), 64'd1);
        chk("first64", first_w[1], 64'd14514284786278117030);
        chk("w10k64", w10k[1], 64'd9981545732273789042);
        rdy64 = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        r64 = 1'b1;
        m_seed(1, 64'd5489);
        @(posedge clk); #1;
        r64 = 1'b0;
        chk("midrst64_tvalid", 64'(v64), 64'd0);
        chk("midrst64_busy", 64'(b64), 64'd0);
        t = 0;
        while (acc[1] < 200 && t < SEED64 + 1000) begin @(posedge clk); #1; t++; end
        chk("midrst64_words", 64'(acc[1] >= 200), 64'd1);
        chk("midrst64_first", first_w[1], 64'd14514284786278117030);
    endtask

    initial begin
        hold[0] = 1'b0; hold[1] = 1'b0;
        acc[0]  = 0;    acc[1]  = 0;
        fork
            run32();
            run64();
        join
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #950000;
        $display("FAIL watchdog: got timeout, expected completion within 95000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
